banco_registros: RTL and testbench

- General-purpose register bank for the single-cycle datapath. It is the consumer of the write-back data selected by the register-bank input mux.
- Provides one synchronous write port, two combinational read ports with write-through bypass, and register 0 hardwired to zero.
- Adds a sequential dump port that walks the bank one register per beat over a valid/ready handshake, for the debug/test harness.

---
 rtl/banco_registros_pkg.sv | 17 +
 rtl/banco_dump_ctrl.sv | 83 ++++++++
 rtl/banco_registros.sv | 82 ++++++++
 tb/tb_banco_registros.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/banco_registros_pkg.sv
// Shared defaults and dump FSM encoding for the general-purpose register bank.
package banco_registros_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  function automatic int nreg_of(input int aw);
    return 1 << aw;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/banco_dump_ctrl.sv
// Dump sequencer: walks the bank one register per valid/ready beat,
// reading through the bank's third (bypassed) read port.
module banco_dump_ctrl
  import banco_registros_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREG   = nreg_of(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    data_d     = data_q;
    rd_addr    = ptr_q + ADDR_W'(1);
    dump_valid = 1'b0;
    dump_busy  = 1'b0;
    dump_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rd_addr = '0;
        if (dump_start) begin
          state_d = ST_SEND;
          ptr_d   = '0;
          data_d  = rd_data;
        end
      end
      ST_SEND: begin
        dump_valid = 1'b1;
        dump_busy  = 1'b1;
        // Beat is captured, not live: later writes to the same register
        // must not disturb a beat that is waiting on backpressure.
        if (dump_ready) begin
          if (ptr_q == LAST) begin
            state_d = ST_DONE;
          end else begin
            ptr_d  = ptr_q + ADDR_W'(1);
            data_d = rd_data;
          end
        end
      end
      ST_DONE: begin
        dump_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
    end
  end

  assign dump_addr = ptr_q;
  assign dump_data = data_q;

endmodule

// File: rtl/banco_registros.sv
// Register bank: one write port, two combinational read ports with
// write-through bypass, r0 hardwired to zero, plus a sequential dump port.
module banco_registros
  import banco_registros_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREG   = nreg_of(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam int NPORT = 3;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [ADDR_W-1:0] rp_addr [NPORT];
  logic [DATA_W-1:0] rp_data [NPORT];
  logic [ADDR_W-1:0] dmp_raddr;

  always_comb begin
    regs_d = regs_q;
    if (we && wa != '0) regs_d[wa] = wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rp_addr[0] = ra1;
  assign rp_addr[1] = ra2;
  assign rp_addr[2] = dmp_raddr;

  // Port 2 is the dump sequencer's private port, so a dump sees the same
  // bypassed value a datapath read would in that cycle.
  for (genvar p = 0; p < NPORT; p++) begin : g_rp
    assign rp_data[p] = (rp_addr[p] == '0)            ? '0 :
                        (we && wa == rp_addr[p])      ? wd :
                                                        regs_q[rp_addr[p]];
  end

  assign rd1 = rp_data[0];
  assign rd2 = rp_data[1];

  banco_dump_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_dump (
    .clk        (clk),
    .rst_n      (rst_n),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .rd_addr    (dmp_raddr),
    .rd_data    (rp_data[2]),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

endmodule

// File: tb/tb_banco_registros.sv
// Randomized and directed bench for banco_registros against a behavioural
// model of the bank contents and of the dump transaction.
module tb_banco_registros;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] wa = '0, ra1 = '0, ra2 = '0;
  logic [DW-1:0] wd = '0;
  logic [DW-1:0] rd1, rd2, dump_data;
  logic          dump_start = 1'b0, dump_ready = 1'b1;
  logic          dump_valid, dump_busy, dump_done;
  logic [AW-1:0] dump_addr;

  banco_registros #(.DATA_W(DW), .ADDR_W(AW), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .dump_start(dump_start), .dump_ready(dump_ready),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_busy(dump_busy), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference state: bank contents plus the dump seen as "beat index and
  // the value snapshotted for it".
  logic [DW-1:0] mem [NREG];
  bit            m_busy, m_done;
  int            m_beat;
  logic [DW-1:0] m_val;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [DW-1:0] peek(input int a);
    if (a == 0) return '0;
    if (we && int'(wa) == a) return wd;
    return mem[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) mem[i] = '0;
    m_busy = 0; m_done = 0; m_beat = 0; m_val = '0;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step();
    bit nxt_done;
    #1;
    chk("rd1", rd1, peek(int'(ra1)));
    chk("rd2", rd2, peek(int'(ra2)));
    chk("dump_valid", dump_valid, m_busy);
    chk("dump_busy", dump_busy, m_busy);
    chk("dump_done", dump_done, m_done);
    if (m_busy) begin
      chk("dump_addr", dump_addr, m_beat);
      chk("dump_data", dump_data, m_val);
    end
    nxt_done = 0;
    if (m_busy) begin
      if (dump_ready) begin
        if (m_beat == NREG - 1) begin
          m_busy = 0;
          nxt_done = 1;
        end else begin
          m_beat++;
          m_val = peek(m_beat);
        end
      end
    end else if (!m_done && dump_start) begin
      m_busy = 1; m_beat = 0; m_val = '0;
    end
    m_done = nxt_done;
    if (we && wa != '0) mem[wa] = wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic hard_reset();
    we = 0; dump_start = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_valid", dump_valid, 0);
    chk("rst_busy", dump_busy, 0);
    chk("rst_done", dump_done, 0);
    chk("rst_daddr", dump_addr, 0);
    chk("rst_ddata", dump_data, 0);
    for (int a = 0; a < NREG; a++) begin
      ra1 = AW'(a); ra2 = AW'(NREG - 1 - a);
      #0.05;
      chk("rst_rd1", rd1, 0);
      chk("rst_rd2", rd2, 0);
    end
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic run_to_done(input string tag);
    bit seen = 0;
    for (int k = 0; k < 3 * NREG && !seen; k++) begin
      #1 if (dump_done) seen = 1;
      step();
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    bit seen;
    model_clear();
    @(negedge clk);
    hard_reset();

    // Bypass write-through then registered read.
    we = 1; wa = 5; wd = 32'hDEADBEEF; ra1 = 5; ra2 = 0;
    #1 chk("byp_deadbeef", rd1, 32'hDEADBEEF);
    step();
    we = 0; ra1 = 5;
    #1 chk("reg_deadbeef", rd1, 32'hDEADBEEF);
    step();

    // r0 write is dropped, reads of r0 stay 0.
    we = 1; wa = 0; wd = 32'hFFFFFFFF; ra1 = 0; ra2 = 0;
    #1 chk("r0_during_rd1", rd1, 0);
    chk("r0_during_rd2", rd2, 0);
    step();
    we = 0;
    #1 chk("r0_after_rd1", rd1, 0);
    chk("r0_after_rd2", rd2, 0);
    step();

    // Preload i*3 and dump with ready held high.
    for (int i = 1; i < NREG; i++) begin
      we = 1; wa = AW'(i); wd = DW'(i * 3);
      step();
    end
    we = 0; dump_ready = 1; dump_start = 1;
    step();
    dump_start = 0;
    seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      #1;
      if (dump_valid) chk("beat_addr_seq", dump_addr, k - 1);
      if (dump_done) begin
        seen = 1;
        // Start-sample cycle through done cycle inclusive is NREG+2.
        chk("start_to_done_cycles", k + 1, NREG + 2);
      end
      step();
    end
    if (!seen) chk("dump1_timeout", 0, 1);
    #1 chk("done_one_cycle", dump_done, 0);
    step();

    // Backpressure on beat 7 while its register is overwritten.
    dump_start = 1;
    step();
    dump_start = 0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      #1 if (dump_valid && dump_addr == 7) seen = 1;
      else step();
    end
    if (!seen) chk("reach_beat7", 0, 1);
    dump_ready = 0;
    for (int j = 0; j < 4; j++) begin
      we = (j == 0); wa = 7; wd = 32'h12345678;
      dump_start = (j == 1);
      #1 chk("bp_hold_data", dump_data, 21);
      chk("bp_hold_addr", dump_addr, 7);
      step();
    end
    dump_start = 0;
    dump_ready = 1; we = 1; wa = 8; wd = 32'hCAFE0008;
    step();
    we = 0;
    #1 chk("beat8_new_val", dump_data, 32'hCAFE0008);
    chk("beat8_addr", dump_addr, 8);
    step();
    step();
    #1 chk("at_beat10", dump_addr, 10);
    hard_reset();
    dump_start = 1;
    step();
    dump_start = 0;
    #1 chk("fresh_addr", dump_addr, 0);
    chk("fresh_valid", dump_valid, 1);
    run_to_done("dump_fresh");

    // Random traffic with concurrent dumps and backpressure.
    for (int c = 0; c < 1500; c++) begin
      we = 1'($urandom_range(0, 1));
      wa = AW'($urandom);
      wd = $urandom;
      ra1 = AW'($urandom);
      ra2 = ($urandom_range(0, 7) == 0) ? ra1 : AW'($urandom);
      if ($urandom_range(0, 3) == 0) ra1 = wa;
      dump_start = ($urandom_range(0, 15) == 0);
      dump_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
